// File: rtl/vo_timing_gen_if.sv
// Video output bus: DMA read request/return on one side, encoder syncs and pixels on the other.
// The master modport is the timing generator's view of the bus.
interface vo_timing_gen_if;
    logic        vo_vs;
    logic        vo_de;
    logic [15:0] video_data;
    logic        video_de;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        sof;

    modport master (
        output vo_vs,
        output vo_de,
        output hs,
        output vs,
        output de,
        output rgb,
        output sof,
        input  video_data,
        input  video_de
    );

    modport slave (
        input  vo_vs,
        input  vo_de,
        input  hs,
        input  vs,
        input  de,
        input  rgb,
        input  sof,
        output video_data,
        output video_de
    );
endinterface

// File: rtl/vo_timing_gen.sv
// Display raster timing generator and RGB565 -> RGB888 output formatter.
// Issues DMA read requests and realigns returned pixels with delayed hs/vs/de.
module vo_timing_gen #(
    parameter int H_DISP = 1280,
    parameter int H_FP   = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int V_DISP = 720,
    parameter int V_FP   = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int RD_LAT = 2
) (
    input  logic            video_clk,
    input  logic            rst_n,
    input  logic            en,
    vo_timing_gen_if.master vo,
    output logic            underflow
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_DISP);
    localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_DISP + H_FP);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_ONE      = H_W'(1);

    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_DISP);
    localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_DISP + V_FP);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_DISP + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_ONE      = V_W'(1);

    // Replicate MSBs into the low bits so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;

    logic de_p0, hs_p0, vs_p0, sof_p0;
    logic de_p1, hs_p1, vs_p1, sof_p1;

    logic [RD_LAT-1:0] de_p2, hs_p2, vs_p2;
    logic              de_exp, hs_tap, vs_tap;

    logic        de_p3, hs_p3, vs_p3;
    logic [23:0] rgb_p3;

    // Raster counters; en=0 parks them at the origin so re-enable starts a clean frame.
    always_ff @(posedge video_clk) begin
        if (!rst_n || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    // Stage p0: decode, gated by en so the pipeline drains while disabled
    assign de_p0  = en && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_p0  = en && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_p0  = en && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign sof_p0 = en && (h_cnt == '0) && (v_cnt == '0);

    // Stage p1: DMA request register
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            de_p1  <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            sof_p1 <= 1'b0;
        end else begin
            de_p1  <= de_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            sof_p1 <= sof_p0;
        end
    end

    // Stage p2: RD_LAT-deep delay matching the DMA read latency
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            de_p2 <= '0;
            hs_p2 <= '0;
            vs_p2 <= '0;
        end else begin
            de_p2[0] <= de_p1;
            hs_p2[0] <= hs_p1;
            vs_p2[0] <= vs_p1;
            for (int i = 1; i < RD_LAT; i++) begin
                de_p2[i] <= de_p2[i-1];
                hs_p2[i] <= hs_p2[i-1];
                vs_p2[i] <= vs_p2[i-1];
            end
        end
    end

    assign de_exp = de_p2[RD_LAT-1];
    assign hs_tap = hs_p2[RD_LAT-1];
    assign vs_tap = vs_p2[RD_LAT-1];

    // Stage p3: encoder output register; data is only accepted when expected
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            de_p3  <= 1'b0;
            hs_p3  <= ~HS_POL;
            vs_p3  <= ~VS_POL;
            rgb_p3 <= '0;
        end else begin
            de_p3  <= de_exp;
            hs_p3  <= hs_tap ^ ~HS_POL;
            vs_p3  <= vs_tap ^ ~VS_POL;
            rgb_p3 <= (de_exp && vo.video_de) ? rgb565_to_888(vo.video_data) : '0;
        end
    end

    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (de_exp && !vo.video_de) begin
            underflow <= 1'b1;
        end
    end

    assign vo.vo_de = de_p1;
    assign vo.vo_vs = vs_p1;
    assign vo.sof   = sof_p1;
    assign vo.de    = de_p3;
    assign vo.hs    = hs_p3;
    assign vo.vs    = vs_p3;
    assign vo.rgb   = rgb_p3;

endmodule

// File: tb/tb_vo_timing_gen.sv
// Bench for vo_timing_gen on a small raster: DMA echo, raster-position model, directed checks.
// Two instances run in lockstep, one with active-high and one with active-low syncs.
`timescale 1ns/1ps
module tb_vo_timing_gen;
    localparam int H_DISP = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_DISP = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int RD_LAT = 2;
    localparam int H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int LAG    = RD_LAT + 1;
    localparam int WH_PIX = 2 * H_DISP + 5;

    logic clk = 1'b0;
    logic rst_n, en;
    logic unf1, unf0;
    bit   mode, stray, withhold, cmp_on;
    int   n_checks = 0;
    int   n_fail   = 0;

    vo_timing_gen_if vif1 ();
    vo_timing_gen_if vif0 ();

    vo_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(RD_LAT)
    ) dut1 (.video_clk(clk), .rst_n(rst_n), .en(en), .vo(vif1), .underflow(unf1));

    vo_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(RD_LAT)
    ) dut0 (.video_clk(clk), .rst_n(rst_n), .en(en), .vo(vif0), .underflow(unf0));

    always #5 clk = ~clk;

    function automatic logic [15:0] pattern(input int pix, input bit m);
        if (!m) begin
            case (pix % 4)
                0:       return 16'hF800;
                1:       return 16'h07E0;
                2:       return 16'h001F;
                default: return 16'h8410;
            endcase
        end
        return 16'(pix * 4999 + 16'h1234);
    endfunction

    function automatic logic [23:0] exp888(input logic [15:0] d);
        int r, g, b;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // DMA echo: returns each request RD_LAT cycles later with a pattern keyed by pixel index.
    bit          hq_de [0:7];
    logic [15:0] hq_d  [0:7];
    initial begin
        int epix;
        epix = 0;
        vif1.video_de = 1'b0; vif0.video_de = 1'b0;
        vif1.video_data = '0; vif0.video_data = '0;
        for (int i = 0; i < 8; i++) begin hq_de[i] = 1'b0; hq_d[i] = '0; end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 7; i > 0; i--) begin
                hq_de[i] = hq_de[i-1];
                hq_d[i]  = hq_d[i-1];
            end
            if (vif1.sof === 1'b1) epix = 0;
            hq_de[0] = (vif1.vo_de === 1'b1) && !(withhold && epix == WH_PIX);
            hq_d[0]  = pattern(epix, mode);
            if (vif1.vo_de === 1'b1) epix++;
            vif1.video_de   = hq_de[RD_LAT];
            vif1.video_data = hq_de[RD_LAT] ? hq_d[RD_LAT] : 16'h0000;
            if (!hq_de[RD_LAT] && stray) begin
                vif1.video_de   = 1'b1;
                vif1.video_data = 16'hFFFF;
            end
            vif0.video_de   = vif1.video_de;
            vif0.video_data = vif1.video_data;
        end
    end

    // Model: raster position per cycle; entries age through a history indexed by cycles since issue.
    bit          m_act [0:7], m_hs [0:7], m_vs [0:7], m_sof [0:7], m_wh [0:7];
    logic [23:0] m_rgb [0:7];
    int          mpos;
    bit          munf;
    initial begin
        int mh, mv, pix;
        mpos = 0;
        munf = 1'b0;
        for (int i = 0; i < 8; i++) m_rgb[i] = '0;
        forever begin
            @(posedge clk);
            mh  = mpos % H_TOT;
            mv  = mpos / H_TOT;
            pix = mv * H_DISP + mh;
            for (int i = 7; i > 0; i--) begin
                m_act[i] = m_act[i-1]; m_hs[i] = m_hs[i-1]; m_vs[i] = m_vs[i-1];
                m_sof[i] = m_sof[i-1]; m_wh[i] = m_wh[i-1]; m_rgb[i] = m_rgb[i-1];
            end
            if (rst_n !== 1'b1) begin
                for (int i = 0; i < 8; i++) begin
                    m_act[i] = 0; m_hs[i] = 0; m_vs[i] = 0; m_sof[i] = 0; m_wh[i] = 0; m_rgb[i] = '0;
                end
                mpos = 0;
                munf = 1'b0;
            end else begin
                m_act[0] = en && mh < H_DISP && mv < V_DISP;
                m_hs[0]  = en && mh >= H_DISP + H_FP && mh < H_DISP + H_FP + H_SYNC;
                m_vs[0]  = en && mv >= V_DISP + V_FP && mv < V_DISP + V_FP + V_SYNC;
                m_sof[0] = en && mpos == 0;
                m_wh[0]  = m_act[0] && withhold && pix == WH_PIX;
                m_rgb[0] = m_wh[0] ? 24'h0 : exp888(pattern(pix, mode));
                if (m_act[LAG] && m_wh[LAG]) munf = 1'b1;
                mpos = en ? (mpos + 1) % FRAME : 0;
            end
        end
    end

    // Per-cycle comparison of every output of both instances against the model.
    initial begin
        logic [31:0] exp1, exp0, got1, got0;
        logic [23:0] e_rgb;
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                e_rgb = m_act[LAG] ? m_rgb[LAG] : 24'h0;
                exp1 = {1'b0, m_vs[0], m_act[0], m_sof[0], m_hs[LAG], m_vs[LAG], m_act[LAG], munf, e_rgb};
                exp0 = {1'b0, m_vs[0], m_act[0], m_sof[0], ~m_hs[LAG], ~m_vs[LAG], m_act[LAG], munf, e_rgb};
                got1 = {1'b0, vif1.vo_vs, vif1.vo_de, vif1.sof, vif1.hs, vif1.vs, vif1.de, unf1, vif1.rgb};
                got0 = {1'b0, vif0.vo_vs, vif0.vo_de, vif0.sof, vif0.hs, vif0.vs, vif0.de, unf0, vif0.rgb};
                check("cycle_pol1", got1, exp1);
                check("cycle_pol0", got0, exp0);
            end
        end
    end

    task automatic measure(output int c_vode, output int c_de, output int c_hs, output int c_vs,
                           output int c_sof, output int c_hs0, output int c_vs0);
        c_vode = 0; c_de = 0; c_hs = 0; c_vs = 0; c_sof = 0; c_hs0 = 0; c_vs0 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            c_vode += int'(vif1.vo_de);
            c_de   += int'(vif1.de);
            c_hs   += int'(vif1.hs);
            c_vs   += int'(vif1.vs);
            c_sof  += int'(vif1.sof);
            c_hs0  += int'(!vif0.hs);
            c_vs0  += int'(!vif0.vs);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vo_de"}, vif1.vo_de, 0);
        check({tag, "_vo_vs"}, vif1.vo_vs, 0);
        check({tag, "_sof"}, vif1.sof, 0);
        check({tag, "_de"}, vif1.de, 0);
        check({tag, "_rgb"}, vif1.rgb, 0);
        check({tag, "_unf"}, unf1, 0);
        check({tag, "_hs_pol1"}, vif1.hs, 0);
        check({tag, "_vs_pol1"}, vif1.vs, 0);
        check({tag, "_hs_pol0"}, vif0.hs, 1);
        check({tag, "_vs_pol0"}, vif0.vs, 1);
    endtask

    initial begin
        int c_vode, c_de, c_hs, c_vs, c_sof, c_hs0, c_vs0;
        rst_n = 1'b0; en = 1'b0;
        mode = 1'b0; stray = 1'b0; withhold = 1'b0; cmp_on = 1'b0;
        tick(3);
        cmp_on = 1'b1;
        check_reset_values("reset");

        // Start: first enabled cycle at origin, request one cycle later
        rst_n = 1'b1; en = 1'b1;
        tick(1);
        check("start_sof", vif1.sof, 1);
        check("start_vo_de", vif1.vo_de, 1);
        check("start_vo_vs", vif1.vo_vs, 0);
        tick(2);
        check("de_lag_early", vif1.de, 0);
        tick(1);
        check("de_lag3", vif1.de, 1);
        check("rgb_red", vif1.rgb, 24'hFF0000);
        tick(1);
        check("rgb_green", vif1.rgb, 24'h00FF00);
        tick(1);
        check("rgb_blue", vif1.rgb, 24'h0000FF);
        tick(1);
        check("rgb_grey", vif1.rgb, 24'h848284);
        check("unf_clean", unf1, 0);

        tick(92);
        check("sof_period", vif1.sof, 1);
        measure(c_vode, c_de, c_hs, c_vs, c_sof, c_hs0, c_vs0);
        check("frame_vo_de", c_vode, 32);
        check("frame_de", c_de, 32);
        check("frame_hs", c_hs, 14);
        check("frame_vs", c_vs, 14);
        check("frame_sof", c_sof, 1);
        check("frame_hs_low_pol0", c_hs0, 14);
        check("frame_vs_low_pol0", c_vs0, 14);
        tick(1);
        check("sof_period2", vif1.sof, 1);

        // Ramp data with stray returns during blanking
        mode = 1'b1; stray = 1'b1;
        tick(FRAME);
        check("stray_unf", unf1, 0);
        check("stray_sof", vif1.sof, 1);
        mode = 1'b0; stray = 1'b0;

        // Missing pixel 5 of line 2
        withhold = 1'b1;
        tick(35);
        check("wh_unf_before", unf1, 0);
        tick(1);
        check("wh_de", vif1.de, 1);
        check("wh_rgb", vif1.rgb, 0);
        check("wh_unf", unf1, 1);
        withhold = 1'b0;
        tick(62);
        check("wh_next_sof", vif1.sof, 1);

        // Drop en mid-line
        tick(17);
        en = 1'b0;
        tick(1);
        check("endrop_vo_de", vif1.vo_de, 0);
        tick(3);
        check("endrop_de", vif1.de, 0);
        tick(8);
        check("endrop_unf_hold", unf1, 1);
        check("endrop_sof", vif1.sof, 0);
        en = 1'b1;
        tick(1);
        check("reen_sof", vif1.sof, 1);
        check("reen_vo_vs", vif1.vo_vs, 0);
        measure(c_vode, c_de, c_hs, c_vs, c_sof, c_hs0, c_vs0);
        check("reen_vo_de", c_vode, 32);
        check("reen_de", c_de, 32);
        check("reen_vs", c_vs, 14);
        check("reen_sof_cnt", c_sof, 1);
        tick(1);
        check("reen_period", vif1.sof, 1);
        check("reen_unf", unf1, 1);

        // Reset mid active line with returns in flight
        tick(5);
        check("pre_rst_de", vif1.de, 1);
        check("pre_rst_vo_de", vif1.vo_de, 1);
        rst_n = 1'b0;
        tick(1);
        check_reset_values("midrst");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_sof", vif1.sof, 1);
        measure(c_vode, c_de, c_hs, c_vs, c_sof, c_hs0, c_vs0);
        check("post_rst_vo_de", c_vode, 32);
        check("post_rst_de", c_de, 32);
        check("post_rst_vs", c_vs, 14);
        check("post_rst_sof_cnt", c_sof, 1);
        tick(1);
        check("post_rst_period", vif1.sof, 1);
        check("post_rst_unf", unf1, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
